skid_buffer: RTL



---
 rtl/skid_buffer.sv | 110 +++++++++++
 1 files changed

// File: rtl/skid_buffer.sv
// skid_buffer
//   Two-entry valid/ready register slice. Cuts both the forward (valid/data)
//   and the return (ready) path: every output is a flop, so there is no
//   combinational route from any input to any output, while a sustained
//   throughput of one word per cycle is kept.
//
//   Parameters
//     Width      data word width in bits (>= 1)
//
//   Ports
//     clk_i      rising-edge clock
//     rst_ni     asynchronous active-low reset
//     s_valid_i  upstream word valid
//     s_data_i   upstream word
//     s_ready_o  slice can accept a word (registered)
//     m_valid_o  downstream word valid (registered)
//     m_data_o   downstream word (registered, main register)
//     m_ready_i  downstream accepts word
//     count_o    number of words held, 0..2 (registered)
module skid_buffer #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             s_valid_i,
    input  logic [Width-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [Width-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic [1:0]       count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t           state_q;
    logic [Width-1:0] skid_q;
    logic             accept;
    logic             xfer;

    // Both handshakes are formed from registered outputs, so the slice only
    // ever looks at its own flops plus the partner's valid/ready.
    assign accept = s_valid_i & s_ready_o;
    assign xfer   = m_valid_o & m_ready_i;

    // ---- single registered stage: state, main register (m_data_o), skid ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= EMPTY;
            s_ready_o <= 1'b0;
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            skid_q    <= '0;
            count_o   <= 2'd0;
        end else begin
            case (state_q)
                EMPTY: begin
                    // s_ready_o is low only on the first edge after reset;
                    // raising it here means no word is taken on that edge.
                    s_ready_o <= 1'b1;
                    if (accept) begin
                        m_data_o  <= s_data_i;
                        m_valid_o <= 1'b1;
                        count_o   <= 2'd1;
                        state_q   <= BUSY;
                    end else begin
                        m_valid_o <= 1'b0;
                        count_o   <= 2'd0;
                    end
                end
                BUSY: begin
                    if (accept && xfer) begin
                        m_data_o <= s_data_i;
                    end else if (accept) begin
                        // Downstream stalled while a word was in flight:
                        // park it in the skid register and close the door.
                        skid_q    <= s_data_i;
                        s_ready_o <= 1'b0;
                        count_o   <= 2'd2;
                        state_q   <= FULL;
                    end else if (xfer) begin
                        m_valid_o <= 1'b0;
                        count_o   <= 2'd0;
                        state_q   <= EMPTY;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        m_data_o  <= skid_q;
                        s_ready_o <= 1'b1;
                        count_o   <= 2'd1;
                        state_q   <= BUSY;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to an empty slice.
                    s_ready_o <= 1'b1;
                    m_valid_o <= 1'b0;
                    count_o   <= 2'd0;
                    state_q   <= EMPTY;
                end
            endcase
        end
    end

endmodule
